// File: rtl/fifo_pkg.sv
// Shared sizing constants and types for the FIFO read-side output buffer.
// Used by fifo_skid_buf and fifo_rd_port (optional FIFO_RD_CNT_EN lives in the top).
package fifo_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = 2;
  localparam int PTR_W     = 1;

  typedef logic [OCC_W-1:0] occ_t;
  typedef logic [PTR_W-1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry circular buffer holding words returned by the FIFO storage.
// Supports write, pop and flush in the same cycle; flush wins over both.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_head,
  output logic [OCC_W-1:0] o_occ
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [BUF_DEPTH];
  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  occ_t             occ_q, occ_d;
  logic             do_pop;
  logic             do_wr;

  // A write into a full buffer is only legal when the head leaves the same edge.
  always_comb begin
    do_pop = i_pop && (occ_q != '0) && !i_flush;
    do_wr  = i_wr && !i_flush && (do_pop || (occ_q != occ_t'(BUF_DEPTH)));
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (i_flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (do_wr) begin
        mem_d[tail_q] = i_wr_data;
        tail_d        = ptr_inc(tail_q);
      end
      if (do_pop) begin
        head_d = ptr_inc(head_q);
      end
      case ({do_wr, do_pop})
        2'b10:   occ_d = occ_q + occ_t'(1);
        2'b01:   occ_d = occ_q - occ_t'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  always_comb begin
    o_head = mem_q[head_q];
    o_occ  = occ_q;
  end

endmodule

// File: rtl/fifo_rd_port.sv
// Read-side controller: issues storage reads, tracks the in-flight return and
// streams buffered words downstream. Optional delivered-word counter: FIFO_RD_CNT_EN.
module fifo_rd_port
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_empty,
  output logic             o_rd_en,
  input  logic [WIDTH-1:0] i_rd_data,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_W-1:0] o_rd_cnt
`endif
);

  logic             inflight_q, inflight_d;
  logic             pop;
  logic             buf_wr;
  logic [OCC_W:0]   committed;
  logic [OCC_W-1:0] occ;
  logic [WIDTH-1:0] head;

  // Words already owned (buffered + returning) minus the one leaving must leave room.
  always_comb begin
    o_valid    = (occ != '0);
    o_data     = head;
    pop        = o_valid && i_ready;
    committed  = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q} - {{OCC_W{1'b0}}, pop};
    o_rd_en    = !i_empty && !i_flush && !i_rst && (committed < (OCC_W+1)'(BUF_DEPTH));
    inflight_d = o_rd_en;
    buf_wr     = inflight_q && !i_flush;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  fifo_skid_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr      (buf_wr),
    .i_wr_data (i_rd_data),
    .i_pop     (pop),
    .i_flush   (i_flush),
    .o_head    (head),
    .o_occ     (occ)
  );

`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

  // Flush suppresses the pop, so a word presented in the flush cycle is not counted.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (pop && !i_flush) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign o_rd_cnt = rd_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule
